// File: rtl/axi4_stream_pattern_source.sv
// AXI4-Stream master that emits a bounded run of patterned beats.
// Optional tlast framing and inter-beat gaps are supported.
module axi4_stream_pattern_source #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      COUNT_WIDTH   = 16,
  parameter int unsigned      PKT_LEN_WIDTH = 8,
  parameter int unsigned      GAP_WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS          = WIDTH'(8'hB8)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [COUNT_WIDTH-1:0]   beat_count,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         seed,
  input  logic [GAP_WIDTH-1:0]     gap_cycles,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   beats_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                   state, state_n;
  logic [WIDTH-1:0]         data_n;
  logic                     valid_n, last_n, busy_n, done_n;
  logic [COUNT_WIDTH-1:0]   sent_n, total_q, total_n;
  logic [PKT_LEN_WIDTH-1:0] pkt_q, pkt_n, plen_q, plen_n;
  logic [1:0]               mode_q, mode_n;
  logic [WIDTH-1:0]         seed_q, seed_n;
  logic [GAP_WIDTH-1:0]     gap_q, gap_n, gcnt_q, gcnt_n;

  logic                     hs;
  logic [COUNT_WIDTH-1:0]   sent_inc;
  logic [PKT_LEN_WIDTH-1:0] pkt_adv;

  assign hs       = m_axis_tvalid && m_axis_tready;
  assign sent_inc = beats_sent + COUNT_WIDTH'(1);
  assign pkt_adv  = m_axis_tlast ? '0 : pkt_q + PKT_LEN_WIDTH'(1);

  function automatic logic [WIDTH-1:0] next_value(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] s);
    case (m)
      2'd0:    next_value = v + WIDTH'(1);
      2'd1:    next_value = {v[WIDTH-2:0], ^(v & TAPS)};
      2'd2:    next_value = s;
      default: next_value = {v[WIDTH-2:0], v[WIDTH-1]};
    endcase
  endfunction

  // tlast for the beat following `sent` accepted beats, `pkt` of them in this packet
  function automatic logic beat_last(input logic [COUNT_WIDTH-1:0]   sent,
                                     input logic [COUNT_WIDTH-1:0]   total,
                                     input logic [PKT_LEN_WIDTH-1:0] pkt,
                                     input logic [PKT_LEN_WIDTH-1:0] plen);
    beat_last = (COUNT_WIDTH'(sent + COUNT_WIDTH'(1)) == total) ||
                ((plen != '0) && (PKT_LEN_WIDTH'(pkt + PKT_LEN_WIDTH'(1)) == plen));
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      beats_sent    <= '0;
      total_q       <= '0;
      pkt_q         <= '0;
      plen_q        <= '0;
      mode_q        <= '0;
      seed_q        <= '0;
      gap_q         <= '0;
      gcnt_q        <= '0;
    end else begin
      state         <= state_n;
      m_axis_tdata  <= data_n;
      m_axis_tvalid <= valid_n;
      m_axis_tlast  <= last_n;
      busy          <= busy_n;
      done          <= done_n;
      beats_sent    <= sent_n;
      total_q       <= total_n;
      pkt_q         <= pkt_n;
      plen_q        <= plen_n;
      mode_q        <= mode_n;
      seed_q        <= seed_n;
      gap_q         <= gap_n;
      gcnt_q        <= gcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = m_axis_tdata;
    valid_n = m_axis_tvalid;
    last_n  = m_axis_tlast;
    busy_n  = busy;
    done_n  = 1'b0;
    sent_n  = beats_sent;
    total_n = total_q;
    pkt_n   = pkt_q;
    plen_n  = plen_q;
    mode_n  = mode_q;
    seed_n  = seed_q;
    gap_n   = gap_q;
    gcnt_n  = gcnt_q;
    case (state)
      IDLE: begin
        if (start) begin
          sent_n = '0;
          if (beat_count != '0) begin
            total_n = beat_count;
            plen_n  = pkt_len;
            mode_n  = mode;
            seed_n  = seed;
            gap_n   = gap_cycles;
            pkt_n   = '0;
            state_n = SEND;
            busy_n  = 1'b1;
            valid_n = 1'b1;
            if (mode == 2'd3 || (mode == 2'd1 && seed == '0)) data_n = WIDTH'(1);
            else                                              data_n = seed;
            last_n  = beat_last('0, beat_count, '0, pkt_len);
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (hs) begin
          sent_n = sent_inc;
          pkt_n  = pkt_adv;
          if (sent_inc == total_q) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (gap_q != '0) begin
            state_n = GAP;
            valid_n = 1'b0;
            gcnt_n  = gap_q;
          end else begin
            data_n = next_value(mode_q, m_axis_tdata, seed_q);
            last_n = beat_last(sent_inc, total_q, pkt_adv, plen_q);
          end
        end
      end
      GAP: begin
        // data stays frozen during the gap; the next beat is formed on exit
        if (gcnt_q == GAP_WIDTH'(1)) begin
          state_n = SEND;
          valid_n = 1'b1;
          data_n  = next_value(mode_q, m_axis_tdata, seed_q);
          last_n  = beat_last(beats_sent, total_q, pkt_q, plen_q);
        end else begin
          gcnt_n = gcnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_stream_pattern_source.sv
// Bench for axi4_stream_pattern_source: directed scenarios plus randomized runs
// compared against a beat-list model built from the pattern rules.
module tb_axi4_stream_pattern_source;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;
  localparam int unsigned GW = 4;
  localparam logic [W-1:0] TAPS_TB = 8'hB8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] beat_count = '0;
  logic [PW-1:0] pkt_len = '0;
  logic [1:0]    mode = '0;
  logic [W-1:0]  seed = '0;
  logic [GW-1:0] gap_cycles = '0;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] beats_sent;

  axi4_stream_pattern_source dut (
    .clk(clk), .resetn(resetn), .start(start), .beat_count(beat_count),
    .pkt_len(pkt_len), .mode(mode), .seed(seed), .gap_cycles(gap_cycles),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .beats_sent(beats_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] got_d[$];
  logic         got_l[$];
  int           got_c[$];
  logic [W-1:0] exp_d[$];
  logic         exp_l[$];
  int           cyc = 0;
  int           done_cnt = 0;
  int           last_done_cyc = 0;
  int           stab_err = 0;
  logic         pv = 1'b0, ph = 1'b0, plst = 1'b0;
  logic [W-1:0] pd = '0;

  // Observes handshakes, done pulses and valid/data stability between clock edges
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      pv = 1'b0;
    end else begin
      if (pv && !ph && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== plst))
        stab_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        got_c.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      pv = m_axis_tvalid; ph = m_axis_tvalid && m_axis_tready;
      pd = m_axis_tdata;  plst = m_axis_tlast;
    end
  end

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
    int ones = 0;
    for (int b = 0; b < W; b++) if (v[b] && TAPS_TB[b]) ones++;
    return {v[W-2:0], 1'(ones % 2)};
  endfunction

  task automatic build_exp(input int md, input logic [W-1:0] sd, input int n, input int pl);
    logic [W-1:0] v;
    exp_d.delete(); exp_l.delete();
    v = (md == 1 && sd == '0) ? W'(1) : sd;
    for (int i = 0; i < n; i++) begin
      case (md)
        0: exp_d.push_back(W'(int'(sd) + i));
        1: begin exp_d.push_back(v); v = lfsr_step(v); end
        2: exp_d.push_back(sd);
        default: exp_d.push_back(W'(1 << (i % W)));
      endcase
      exp_l.push_back((i == n - 1) || (pl != 0 && ((i + 1) % pl) == 0));
    end
  endtask

  function automatic int seq_errors();
    int e = 0;
    if (got_d.size() != exp_d.size()) e++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) e++;
    return e;
  endfunction

  task automatic do_start(input logic [1:0] md, input logic [W-1:0] sd, input logic [CW-1:0] n,
                          input logic [PW-1:0] pl, input logic [GW-1:0] gp);
    @(posedge clk); #1;
    mode = md; seed = sd; beat_count = n; pkt_len = pl; gap_cycles = gp; start = 1'b1;
    got_d.delete(); got_l.delete(); got_c.delete();
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom); seed = W'($urandom); beat_count = CW'($urandom);
    pkt_len = PW'($urandom); gap_cycles = GW'($urandom);
  endtask

  task automatic wait_done(input bit rnd, input int limit, output int busy_low, output bit to);
    busy_low = 0; to = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (done) begin to = 1'b0; break; end
      if (!busy) busy_low++;
      @(posedge clk); #1;
      m_axis_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); else n_pass++;
    n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); else n_pass++;
    n_checks++; if (m_axis_tdata !== '0) $display("FAIL reset_tdata got=%h want=00", m_axis_tdata); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_checks++; if (beats_sent !== '0) $display("FAIL reset_beats_sent got=%0d want=0", beats_sent); else n_pass++;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_incrementing();
    int bl, e; bit to;
    m_axis_tready = 1'b1;
    build_exp(0, 8'hFE, 4, 2);
    do_start(2'd0, 8'hFE, 16'd4, 8'd2, 4'd0);
    wait_done(1'b0, 100, bl, to);
    e = seq_errors();
    n_checks++; if (to !== 1'b0) $display("FAIL inc_timeout got=%b want=0", to); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL inc_seq errors=%0d want=0 got_n=%0d", e, got_d.size()); else n_pass++;
    n_checks++; if (got_c[3] - got_c[0] !== 3) $display("FAIL inc_consecutive span=%0d want=3", got_c[3] - got_c[0]); else n_pass++;
    n_checks++; if (last_done_cyc !== got_c[3] + 1) $display("FAIL inc_done_timing got=%0d want=%0d", last_done_cyc, got_c[3] + 1); else n_pass++;
    n_checks++; if (beats_sent !== 16'd4) $display("FAIL inc_beats_sent got=%0d want=4", beats_sent); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL inc_after_done done=%b busy=%b want=0,0", done, busy); else n_pass++;
  endtask

  task automatic test_lfsr();
    int bl, e; bit to;
    m_axis_tready = 1'b1;
    build_exp(1, 8'h01, 5, 0);
    do_start(2'd1, 8'h01, 16'd5, 8'd0, 4'd0);
    wait_done(1'b1, 200, bl, to);
    e = seq_errors();
    n_checks++; if (to !== 1'b0) $display("FAIL lfsr_timeout got=%b want=0", to); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL lfsr_seq errors=%0d want=0", e); else n_pass++;
    n_checks++; if (got_d[4] !== 8'h11) $display("FAIL lfsr_beat5 got=%h want=11", got_d[4]); else n_pass++;
    build_exp(1, 8'h00, 3, 0);
    do_start(2'd1, 8'h00, 16'd3, 8'd0, 4'd0);
    wait_done(1'b1, 200, bl, to);
    e = seq_errors();
    n_checks++; if (got_d[0] !== 8'h01) $display("FAIL lfsr_zero_seed got=%h want=01", got_d[0]); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL lfsr_zero_seq errors=%0d want=0", e); else n_pass++;
  endtask

  task automatic test_stall();
    int bl, e; bit to;
    m_axis_tready = 1'b0;
    build_exp(0, 8'h10, 3, 0);
    do_start(2'd0, 8'h10, 16'd3, 8'd0, 4'd0);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11)
        $display("FAIL stall_hold%0d valid=%b data=%h want 1,11", k, m_axis_tvalid, m_axis_tdata);
      else n_pass++;
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    wait_done(1'b0, 100, bl, to);
    e = seq_errors();
    n_checks++; if (to !== 1'b0) $display("FAIL stall_timeout got=%b want=0", to); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL stall_seq errors=%0d want=0 got_n=%0d", e, got_d.size()); else n_pass++;
  endtask

  task automatic test_walking_gap();
    int bl, e, bad, d0; bit to;
    m_axis_tready = 1'b1;
    d0 = done_cnt;
    build_exp(3, 8'h5A, 10, 0);
    do_start(2'd3, 8'h5A, 16'd10, 8'd0, 4'd2);
    wait_done(1'b0, 200, bl, to);
    e = seq_errors();
    bad = 0;
    for (int i = 1; i < got_c.size(); i++) if (got_c[i] - got_c[i-1] != 3) bad++;
    n_checks++; if (to !== 1'b0) $display("FAIL walk_timeout got=%b want=0", to); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL walk_seq errors=%0d want=0", e); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL walk_gap_spacing bad=%0d want=0", bad); else n_pass++;
    n_checks++; if (bl !== 0) $display("FAIL walk_busy_low cycles=%0d want=0", bl); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL walk_done_count got=%0d want=1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_ignored_start();
    int bl, e, d0; bit to;
    m_axis_tready = 1'b1;
    d0 = done_cnt;
    build_exp(0, 8'h20, 6, 0);
    do_start(2'd0, 8'h20, 16'd6, 8'd0, 4'd1);
    @(posedge clk); #1;
    mode = 2'd2; beat_count = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1, 300, bl, to);
    e = seq_errors();
    n_checks++; if (to !== 1'b0) $display("FAIL ign_timeout got=%b want=0", to); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL ign_seq errors=%0d want=0", e); else n_pass++;
    n_checks++; if (beats_sent !== 16'd6) $display("FAIL ign_beats_sent got=%0d want=6", beats_sent); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL ign_done_count got=%0d want=1", done_cnt - d0); else n_pass++;
    do_start(2'd0, 8'h33, 16'd0, 8'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0)
      $display("FAIL zero_count_done done=%b busy=%b valid=%b want 1,0,0", done, busy, m_axis_tvalid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || m_axis_tvalid !== 1'b0 || got_d.size() !== 0)
      $display("FAIL zero_count_after done=%b valid=%b beats=%0d want 0,0,0", done, m_axis_tvalid, got_d.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int bl, e, d0; bit to;
    m_axis_tready = 1'b1;
    do_start(2'd0, 8'h80, 16'd8, 8'd0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = done_cnt;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || beats_sent !== '0 || done !== 1'b0)
      $display("FAIL midreset_state valid=%b busy=%b sent=%0d done=%b want 0,0,0,0", m_axis_tvalid, busy, beats_sent, done);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (done_cnt - d0 !== 0 || m_axis_tvalid !== 1'b0) $display("FAIL midreset_no_done dones=%0d valid=%b want 0,0", done_cnt - d0, m_axis_tvalid); else n_pass++;
    build_exp(0, 8'h40, 5, 3);
    do_start(2'd0, 8'h40, 16'd5, 8'd3, 4'd0);
    wait_done(1'b0, 100, bl, to);
    e = seq_errors();
    n_checks++; if (to !== 1'b0) $display("FAIL midreset_rerun_timeout got=%b want=0", to); else n_pass++;
    n_checks++; if (e !== 0) $display("FAIL midreset_rerun_seq errors=%0d want=0", e); else n_pass++;
  endtask

  task automatic test_random();
    int bl, e, d0, md, n, pl, gp; bit to;
    logic [W-1:0] sd;
    for (int it = 0; it < 20; it++) begin
      md = $urandom_range(0, 3); n = $urandom_range(1, 20);
      pl = $urandom_range(0, 5); gp = $urandom_range(0, 3);
      sd = W'($urandom);
      m_axis_tready = ($urandom_range(0, 1) != 0);
      d0 = done_cnt;
      build_exp(md, sd, n, pl);
      do_start(2'(md), sd, CW'(n), PW'(pl), GW'(gp));
      wait_done(1'b1, 2000, bl, to);
      e = seq_errors();
      n_checks++; if (to !== 1'b0) $display("FAIL rand%0d_timeout got=%b want=0", it, to); else n_pass++;
      n_checks++; if (e !== 0) $display("FAIL rand%0d_seq mode=%0d n=%0d pl=%0d errors=%0d want=0", it, md, n, pl, e); else n_pass++;
      n_checks++; if (beats_sent !== CW'(n)) $display("FAIL rand%0d_beats_sent got=%0d want=%0d", it, beats_sent, n); else n_pass++;
      n_checks++; if (done_cnt - d0 !== 1) $display("FAIL rand%0d_done_count got=%0d want=1", it, done_cnt - d0); else n_pass++;
    end
    n_checks++; if (stab_err !== 0) $display("FAIL stability_violations got=%0d want=0", stab_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_lfsr();
    test_stall();
    test_walking_gap();
    test_ignored_start();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule

// File: doc/axi4_stream_pattern_source.md
Name: axi4_stream_pattern_source

Overview:
- Programmable AXI4-Stream master that generates a bounded run of data beats with selectable patterns and optional packet framing via tlast.
- Acts as the transmitting end that feeds stream sinks such as axi4_stream_fifo in block-level benches and on-chip loopback/BIST paths.
- Control is a start pulse plus a busy/done status; the data interface obeys full AXI4-Stream valid/ready rules under arbitrary backpressure.

Parameters:
WIDTH, 8, tdata width in bits (>=2)
COUNT_WIDTH, 16, width of beat_count and beats_sent
PKT_LEN_WIDTH, 8, width of pkt_len
GAP_WIDTH, 4, width of gap_cycles
TAPS, 8'hB8, LFSR feedback tap mask, WIDTH bits

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a run; sampled only in IDLE
beat_count  in  COUNT_WIDTH  number of beats in the run
pkt_len  in  PKT_LEN_WIDTH  beats per packet; 0 = single packet covering the whole run
mode  in  2  0 incrementing, 1 LFSR, 2 constant, 3 walking-ones
seed  in  WIDTH  first data value (modes 0-2)
gap_cycles  in  GAP_WIDTH  idle cycles inserted after each accepted non-final beat
m_axis_tdata  out  WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tlast  out  1  end of packet
m_axis_tready  in  1  sink ready
busy  out  1  high from the cycle after an accepted start until the final handshake
done  out  1  one-cycle pulse on run completion
beats_sent  out  COUNT_WIDTH  accepted beats in the current/last run

Behaviour:
- Reset is synchronous on resetn==0 and overrides everything, including mid-run.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, beats_sent=0, state=IDLE.
- All outputs are registered; no combinational path from m_axis_tready to any output.
- States: IDLE, SEND, GAP.
- IDLE, start=1 and beat_count!=0:
  - Latch beat_count, pkt_len, mode, seed and gap_cycles.
  - Clear beats_sent and the packet counter.
  - Next cycle: state=SEND, busy=1, tvalid=1, tdata=first value.
- IDLE, start=1 and beat_count==0: no beats; done pulses the next cycle; busy stays 0.
- start outside IDLE is ignored. Input changes after start have no effect on the run.
- First value: seed for modes 0 and 2; seed for mode 1, or 1 if seed==0; 1 for mode 3.
- Next value, advanced on every handshake:
  - mode 0: value+1 modulo 2^WIDTH.
  - mode 1: {value[WIDTH-2:0], ^(value & TAPS)}.
  - mode 2: seed.
  - mode 3: rotate left by 1, so MSB wraps to bit 0.
- Handshake is m_axis_tvalid && m_axis_tready. While tvalid=1 without a handshake, tdata and tlast hold stable and tvalid stays high.
- tlast=1 on a beat if it is the final beat of the run, or if pkt_len!=0 and it is the pkt_len-th beat of the current packet. The packet counter resets after each tlast beat.
- On a handshake in SEND, beats_sent increments. Then:
  - Final beat: next cycle state=IDLE, tvalid=0, tlast=0, busy=0, done=1 for exactly one cycle.
  - Else if gap_cycles!=0: state=GAP, tvalid=0 for exactly gap_cycles cycles, then SEND with tvalid=1 and the next value.
  - Else: tvalid stays 1 and the next beat is presented the following cycle, giving 1 beat/cycle with tready held high.
- tdata holds its last value while tvalid=0. beats_sent holds after done until the next accepted start.
- Reset mid-run: tvalid and busy drop on the reset edge. No done pulse is generated; the run is abandoned.

Test Plan:
- mode=0, seed=8'hFE, beat_count=4, pkt_len=2, gap=0, tready=1 -> beats FE,FF,00,01 on 4 consecutive cycles; tlast on beats 2 and 4; done one cycle after beat 4; beats_sent=4.
- mode=1, seed=8'h01, beat_count=5, pkt_len=0 -> data 01,02,04,08,11; tlast only on beat 5; seed=0 run starts at 01.
- mode=0, seed=8'h10, beat_count=3, tready low for 3 cycles while beat 2 valid -> tdata=11 and tvalid held stable through the stall; total beats 10,11,12; no beat lost or duplicated.
- mode=3, beat_count=10, gap_cycles=2 -> 01,02,04,...,80,01,02; exactly 2 tvalid-low cycles between handshakes; busy high throughout; done once.
- Second start while busy, and start with beat_count=0 -> second start ignored (beats_sent matches the first run only); zero-count start yields done with no tvalid and busy=0.
- resetn=0 during beat 3 of an 8-beat run -> next cycle tvalid=0, busy=0, beats_sent=0, no done; a new start afterwards runs normally from seed.
